unified_mem_arbiter: RTL and testbench
======================================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width; MAX_BURST, default 4, maximum consecutive grants to one requester while the other waits.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 core_req, core_we  in  1  core memory request and write strobe (fetch, load or store from the multicycle control).
REQ-005 core_addr  in  AW, core_wdata  in  DW  core command payload.
REQ-006 core_gnt  out  1  core command issued this cycle; core_rvalid  out  1  core read data valid; core_rdata  out  DW.
REQ-007 ldr_req, ldr_we  in  1; ldr_addr  in  AW; ldr_wdata  in  DW  program-loader/debug port command.
REQ-008 ldr_gnt, ldr_rvalid  out  1; ldr_rdata  out  DW  loader grant and read response.
REQ-009 ldr_lock  in  1  when high, the loader has exclusive ownership and the core is never granted.
REQ-010 mem_en, mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW  single-port memory command.
REQ-011 mem_rdata  in  DW  memory read data, valid one cycle after a read command.

Function
REQ-012 State machine states SHALL be IDLE, CORE_OWN and LDR_OWN, holding the previous cycle's grant owner; the burst counter cnt is 3 bits wide and saturates at MAX_BURST.
REQ-013 Each cycle, at most one of core_gnt and ldr_gnt SHALL be high, decided combinationally from the state, cnt, the requests and ldr_lock.
REQ-014 When ldr_lock=1: ldr_gnt=ldr_req; core_gnt=0.
REQ-015 When only one requester is active: grant it, regardless of state and cnt.
REQ-016 When both are active in CORE_OWN with cnt<MAX_BURST: grant the core; in CORE_OWN with cnt>=MAX_BURST: grant the loader.
REQ-017 When both are active in LDR_OWN, the mirror of REQ-016 SHALL apply.
REQ-018 When both are active in IDLE: grant the requester not served by the most recent grant (last_gnt register, reset value core); this is round robin.
REQ-019 The next state SHALL be CORE_OWN/LDR_OWN per this cycle's grant, or IDLE when no grant is issued.
REQ-020 cnt SHALL update as follows: +1 (saturating) when the grant goes to the same owner as the state; 1 on a grant to a new owner; 0 when no grant is issued.
REQ-021 mem_en SHALL equal core_gnt|ldr_gnt; mem_we/addr/wdata SHALL be muxed from the granted requester in the same cycle (zero added latency); when neither is granted, mem_we=0 and the payload outputs are 0.
REQ-022 A granted read (we=0) SHALL set the matching rvalid exactly one cycle later via a registered tag; rdata for both ports SHALL pass mem_rdata through, qualified only by rvalid.
REQ-023 Granted writes SHALL produce no rvalid.
REQ-024 Back-to-back grants are allowed: a read every cycle yields rvalid every cycle, one cycle delayed.
REQ-025 If ldr_lock rises while state is CORE_OWN, the core SHALL lose its grant in that same cycle; a core read granted in the previous cycle SHALL still return its rvalid.
REQ-026 Requests dropped without a grant SHALL be forgotten (no queuing); requesters SHALL hold their payload stable until granted.

Reset
REQ-027 Asserting rst SHALL immediately force: state=IDLE, cnt=0, last_gnt=core, both rvalid tags 0.
REQ-028 The combinational outputs follow from that reset state; with no requests active, all outputs are 0.
REQ-029 An in-flight read response SHALL be discarded on reset.

Structure
REQ-030 The state encoding (IDLE, CORE_OWN, LDR_OWN), the requester ID encoding and the MAX_BURST default SHALL live in the shared processor package used by the control FSM.
REQ-031 The block SHALL be one module with no sub-modules; the round-robin/burst decision SHALL be written as a single combinational process.

Verification
REQ-032 The core reads 0x0000_0010 alone -> core_gnt=1 and mem_addr=0x10 in cycle N; core_rvalid=1 in N+1 with core_rdata=mem_rdata.
REQ-033 Both request continuously from IDLE with last_gnt=core -> grants go ldr x4, then core x4, then ldr, repeating; ldr_gnt and core_gnt are never high together.
REQ-034 ldr_lock=1 with the loader writing 0xDEADBEEF to 0x40 while the core requests -> core_gnt stays 0 throughout; mem_we=1, mem_wdata=0xDEADBEEF.
REQ-035 The core is granted a read in cycle N and ldr_lock rises in N+1 -> core_rvalid=1 in N+1 and ldr_gnt=1 in N+1.
REQ-036 rst is asserted one cycle after a granted read -> no rvalid; state=IDLE and cnt=0 immediately.
REQ-037 Only the core requests, for 10 cycles -> core_gnt=1 on all 10 cycles; cnt saturates at 4 with no switch.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared processor package: arbiter state encoding, requester IDs and burst defaults.
// Also holds the saturating counter helper used by the arbiter decision logic.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CORE_OWN = 2'd1,
      LDR_OWN  = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_LDR  = 1'b1
   } req_id_e;

   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned CNT_W         = 3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic [CNT_W-1:0] lim);
      return (c >= lim) ? lim : c + CNT_W'(1);
   endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Two-requester arbiter (core, program loader) onto a single-port memory with
// burst-limited round robin, loader lock, and one-cycle registered read-valid tags.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_rvalid,
   output logic [DW-1:0] ldr_rdata,
   input  logic          ldr_lock,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_id_e          last_gnt_q, last_gnt_d;
   logic             core_tag_q, core_tag_d;
   logic             ldr_tag_q, ldr_tag_d;

   // Grant decision, owner/burst tracking and read-tag generation in one process.
   always_comb begin
      core_gnt   = 1'b0;
      ldr_gnt    = 1'b0;
      state_d    = IDLE;
      cnt_d      = '0;
      last_gnt_d = last_gnt_q;

      if (ldr_lock) begin
         ldr_gnt = ldr_req;
      end else if (core_req && ldr_req) begin
         unique case (state_q)
            CORE_OWN: begin
               if (cnt_q < BURST_LIM) core_gnt = 1'b1;
               else                   ldr_gnt  = 1'b1;
            end
            LDR_OWN: begin
               if (cnt_q < BURST_LIM) ldr_gnt  = 1'b1;
               else                   core_gnt = 1'b1;
            end
            default: begin
               if (last_gnt_q == REQ_CORE) ldr_gnt  = 1'b1;
               else                        core_gnt = 1'b1;
            end
         endcase
      end else begin
         core_gnt = core_req;
         ldr_gnt  = ldr_req;
      end

      if (core_gnt) begin
         state_d    = CORE_OWN;
         last_gnt_d = REQ_CORE;
         cnt_d      = (state_q == CORE_OWN) ? sat_inc(cnt_q, BURST_LIM) : CNT_W'(1);
      end else if (ldr_gnt) begin
         state_d    = LDR_OWN;
         last_gnt_d = REQ_LDR;
         cnt_d      = (state_q == LDR_OWN) ? sat_inc(cnt_q, BURST_LIM) : CNT_W'(1);
      end

      core_tag_d = core_gnt & ~core_we;
      ldr_tag_d  = ldr_gnt & ~ldr_we;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_gnt_q <= REQ_CORE;
         core_tag_q <= 1'b0;
         ldr_tag_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         core_tag_q <= core_tag_d;
         ldr_tag_q  <= ldr_tag_d;
      end
   end

   // Zero-latency command mux; payload is forced to zero when nobody is granted.
   always_comb begin
      mem_en    = core_gnt | ldr_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (ldr_gnt) begin
         mem_we    = ldr_we;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
      end
   end

   always_comb begin
      core_rvalid = core_tag_q;
      ldr_rvalid  = ldr_tag_q;
      core_rdata  = core_tag_q ? mem_rdata : '0;
      ldr_rdata   = ldr_tag_q  ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a one-cycle-latency
// memory model whose read data is the address XOR a fixed key.
module tb_unified_mem_arbiter;
   import unified_mem_arbiter_pkg::*;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic        clk;
   logic        rst;
   logic        core_req, core_we, ldr_req, ldr_we, ldr_lock;
   logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
   logic        core_gnt, core_rvalid, ldr_gnt, ldr_rvalid;
   logic [31:0] core_rdata, ldr_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   unified_mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .ldr_lock(ldr_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_en && !mem_we) mem_rdata <= mem_addr ^ KEY;

   task automatic drop_all();
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      ldr_req  = 1'b0; ldr_we  = 1'b0; ldr_addr  = '0; ldr_wdata  = '0;
      ldr_lock = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      drop_all();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drop_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({core_gnt, ldr_gnt, mem_en, mem_we, core_rvalid, ldr_rvalid} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got=%b exp=000000",
                  {core_gnt, ldr_gnt, mem_en, mem_we, core_rvalid, ldr_rvalid});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, core_rdata, ldr_rdata} !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_data addr=%h wdata=%h crd=%h lrd=%h exp=0",
                  mem_addr, mem_wdata, core_rdata, ldr_rdata);
      end
      n_checks++;
      if (dut.state_q !== IDLE || dut.cnt_q !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state state=%0d cnt=%0d exp=0/0", dut.state_q, dut.cnt_q);
      end
      rst = 1'b1;
      idle_cycle();
   endtask

   task automatic test_single_read();
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0010;
      #1;
      n_checks++;
      if (core_gnt !== 1'b1 || ldr_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL single_gnt core=%b ldr=%b en=%b we=%b exp=1/0/1/0",
                  core_gnt, ldr_gnt, mem_en, mem_we);
      end
      n_checks++;
      if (mem_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL single_addr got=%h exp=00000010", mem_addr);
      end
      idle_cycle();
      #1;
      n_checks++;
      if (core_rvalid !== 1'b1 || core_rdata !== (32'h10 ^ KEY) || ldr_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rvalid rv=%b rdata=%h lrv=%b exp=1/%h/0",
                  core_rvalid, core_rdata, ldr_rvalid, 32'h10 ^ KEY);
      end
      idle_cycle();
      #1;
      n_checks++;
      if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL single_rvalid_off rv=%b rdata=%h exp=0/0", core_rvalid, core_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic exp_l;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'h1111;
         ldr_req  = 1'b1; ldr_we  = 1'b1; ldr_addr  = 32'h200; ldr_wdata  = 32'h2222;
         #1;
         exp_l = ((i % 8) < 4);
         n_checks++;
         if (ldr_gnt !== exp_l || core_gnt !== !exp_l) begin
            n_fail++;
            $display("FAIL rr_grant cyc=%0d ldr=%b core=%b exp_ldr=%b", i, ldr_gnt, core_gnt, exp_l);
         end
         n_checks++;
         if (mem_addr !== (exp_l ? 32'h200 : 32'h100) ||
             mem_wdata !== (exp_l ? 32'h2222 : 32'h1111) || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_payload cyc=%0d addr=%h wdata=%h we=%b", i, mem_addr, mem_wdata, mem_we);
         end
         n_checks++;
         if (core_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_write_rvalid cyc=%0d crv=%b lrv=%b exp=0/0", i, core_rvalid, ldr_rvalid);
         end
      end
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_lock_write();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ldr_lock = 1'b1;
         ldr_req  = 1'b1; ldr_we  = 1'b1; ldr_addr  = 32'h40; ldr_wdata = 32'hDEAD_BEEF;
         core_req = 1'b1; core_we = 1'b0; core_addr = 32'h80;
         #1;
         n_checks++;
         if (core_gnt !== 1'b0 || ldr_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_grant cyc=%0d core=%b ldr=%b exp=0/1", i, core_gnt, ldr_gnt);
         end
         n_checks++;
         if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL lock_payload cyc=%0d we=%b wdata=%h addr=%h exp=1/deadbeef/40",
                     i, mem_we, mem_wdata, mem_addr);
         end
         n_checks++;
         if (ldr_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_write_rvalid cyc=%0d got=%b exp=0", i, ldr_rvalid);
         end
      end
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_lock_preempt();
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h24;
      #1;
      n_checks++;
      if (core_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL preempt_n_gnt got=%b exp=1", core_gnt);
      end
      @(negedge clk);
      ldr_lock = 1'b1; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h30;
      #1;
      n_checks++;
      if (core_gnt !== 1'b0 || ldr_gnt !== 1'b1 || mem_addr !== 32'h30) begin
         n_fail++;
         $display("FAIL preempt_grant core=%b ldr=%b addr=%h exp=0/1/30", core_gnt, ldr_gnt, mem_addr);
      end
      n_checks++;
      if (core_rvalid !== 1'b1 || core_rdata !== (32'h24 ^ KEY)) begin
         n_fail++;
         $display("FAIL preempt_core_rvalid rv=%b rdata=%h exp=1/%h", core_rvalid, core_rdata, 32'h24 ^ KEY);
      end
      idle_cycle();
      #1;
      n_checks++;
      if (ldr_rvalid !== 1'b1 || ldr_rdata !== (32'h30 ^ KEY) || core_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL preempt_ldr_rvalid lrv=%b lrd=%h crv=%b exp=1/%h/0",
                  ldr_rvalid, ldr_rdata, core_rvalid, 32'h30 ^ KEY);
      end
      idle_cycle();
   endtask

   task automatic test_reset_inflight();
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h50;
      #1;
      n_checks++;
      if (core_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rstflight_gnt got=%b exp=1", core_gnt);
      end
      @(negedge clk);
      drop_all();
      rst = 1'b0;
      #1;
      n_checks++;
      if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rstflight_rvalid rv=%b rdata=%h exp=0/0", core_rvalid, core_rdata);
      end
      n_checks++;
      if (dut.state_q !== IDLE || dut.cnt_q !== 3'd0) begin
         n_fail++;
         $display("FAIL rstflight_state state=%0d cnt=%0d exp=0/0", dut.state_q, dut.cnt_q);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (core_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstflight_late_rvalid got=%b exp=0", core_rvalid);
      end
      rst = 1'b1;
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000 + 32'(4 * i);
         #1;
         exp_cnt = (i < 4) ? 3'(i) : 3'd4;
         n_checks++;
         if (core_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gnt cyc=%0d core=%b ldr=%b exp=1/0", i, core_gnt, ldr_gnt);
         end
         n_checks++;
         if (dut.cnt_q !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_cnt cyc=%0d got=%0d exp=%0d", i, dut.cnt_q, exp_cnt);
         end
         if (i > 0) begin
            n_checks++;
            if (core_rvalid !== 1'b1 || core_rdata !== ((32'h1000 + 32'(4 * (i - 1))) ^ KEY)) begin
               n_fail++;
               $display("FAIL b2b_rvalid cyc=%0d rv=%b rdata=%h exp=1/%h",
                        i, core_rvalid, core_rdata, (32'h1000 + 32'(4 * (i - 1))) ^ KEY);
            end
         end
      end
      @(negedge clk);
      core_req = 1'b0;
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h300; ldr_wdata = 32'h3333;
      #1;
      n_checks++;
      if (ldr_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL b2b_ldr_only ldr=%b core=%b addr=%h exp=1/0/300", ldr_gnt, core_gnt, mem_addr);
      end
      n_checks++;
      if (dut.state_q !== CORE_OWN || dut.cnt_q !== 3'd4 || core_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_sat state=%0d cnt=%0d rv=%b exp=1/4/1", dut.state_q, dut.cnt_q, core_rvalid);
      end
      idle_cycle();
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock_write();
      test_lock_preempt();
      test_reset_inflight();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
